// File: rtl/ro_pair_sched.sv
// ro_pair_sched: ring-oscillator PUF pair measurement sequencer (settle, count, drain, compare).
// Define RO_PAIR_CNT_OUT_EN to expose the held final edge counts on cnt_a/cnt_b.
module ro_pair_sched #(
  parameter int NUM_RO = 16,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 4,
  parameter int WINDOW = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  sel_a,
  input  logic [SEL_W-1:0]  sel_b,
  input  logic [NUM_RO-1:0] ro_out,
  output logic [NUM_RO-1:0] ro_en,
  output logic              busy,
  output logic              done,
  output logic              response,
  output logic              tie,
  output logic              err
`ifdef RO_PAIR_CNT_OUT_EN
  ,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
`endif
);

  localparam int TMAX  = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TMR_W = ($clog2(TMAX) < 2) ? 2 : $clog2(TMAX);
  localparam logic [SEL_W:0] NUM_RO_L = (SEL_W+1)'(NUM_RO);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [TMR_W-1:0]   tmr_r, tmr_nxt_s;
  logic [SEL_W-1:0]   sel_a_r, sel_b_r;
  logic               valid_s, take_s, accept_s, counting_s, finish_s;
  logic [2:0]         sync_a_r, sync_b_r;
  logic               rise_a_s, rise_b_s;
  logic [CNT_W-1:0]   cnt_a_r, cnt_b_r, cnt_a_nxt_s, cnt_b_nxt_s;
  logic [NUM_RO-1:0]  en_mask_s;
  logic [NUM_RO-1:0]  ro_en_r;
  logic               busy_r, done_r, response_r, tie_r, err_r;

  function automatic logic [NUM_RO-1:0] decode(input logic [SEL_W-1:0] idx);
    logic [NUM_RO-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_RO; i++) begin
      v[i] = (idx == SEL_W'(i));
    end
    return v;
  endfunction

  function automatic logic pick(input logic [NUM_RO-1:0] vec, input logic [SEL_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      b = b | (vec[i] & (idx == SEL_W'(i)));
    end
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != {CNT_W{1'b1}})) ? (c + CNT_W'(1)) : c;
  endfunction

  assign valid_s    = (sel_a != sel_b) && ({1'b0, sel_a} < NUM_RO_L) && ({1'b0, sel_b} < NUM_RO_L);
  assign take_s     = (state_r == S_IDLE) && start;
  assign accept_s   = take_s && valid_s;
  assign counting_s = (state_r == S_MEASURE) || (state_r == S_DRAIN);
  assign finish_s   = (state_r == S_DRAIN) && (state_nxt_s == S_DONE);
  // Detector flop is sync[2]; sync[1:0] form the two-flop synchronizer.
  assign rise_a_s   = sync_a_r[1] & ~sync_a_r[2];
  assign rise_b_s   = sync_b_r[1] & ~sync_b_r[2];
  assign en_mask_s  = (state_r == S_IDLE) ? (decode(sel_a) | decode(sel_b))
                                          : (decode(sel_a_r) | decode(sel_b_r));

  // Next-state and phase timer.
  always_comb begin
    state_nxt_s = state_r;
    tmr_nxt_s   = tmr_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (valid_s) begin
            state_nxt_s = S_SETTLE;
            tmr_nxt_s   = TMR_W'(SETTLE - 1);
          end else begin
            state_nxt_s = S_DONE;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (tmr_r == '0) begin
          state_nxt_s = S_MEASURE;
          tmr_nxt_s   = TMR_W'(WINDOW - 1);
        end else begin
          tmr_nxt_s = tmr_r - TMR_W'(1);
        end
      end
      S_MEASURE: begin
        if (tmr_r == '0) begin
          state_nxt_s = S_DRAIN;
          tmr_nxt_s   = TMR_W'(2);
        end else begin
          tmr_nxt_s = tmr_r - TMR_W'(1);
        end
      end
      S_DRAIN: begin
        if (tmr_r == '0) begin
          state_nxt_s = S_DONE;
        end else begin
          tmr_nxt_s = tmr_r - TMR_W'(1);
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
        tmr_nxt_s   = '0;
      end
    endcase
  end

  // Saturating edge counters; any start taken in IDLE clears them.
  always_comb begin
    cnt_a_nxt_s = cnt_a_r;
    cnt_b_nxt_s = cnt_b_r;
    if (take_s) begin
      cnt_a_nxt_s = '0;
      cnt_b_nxt_s = '0;
    end else begin
      cnt_a_nxt_s = sat_inc(cnt_a_r, counting_s & rise_a_s);
      cnt_b_nxt_s = sat_inc(cnt_b_r, counting_s & rise_b_s);
    end
  end

  // State, timer, latched challenge and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      tmr_r   <= '0;
      sel_a_r <= '0;
      sel_b_r <= '0;
      cnt_a_r <= '0;
      cnt_b_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      tmr_r   <= tmr_nxt_s;
      cnt_a_r <= cnt_a_nxt_s;
      cnt_b_r <= cnt_b_nxt_s;
      if (accept_s) begin
        sel_a_r <= sel_a;
        sel_b_r <= sel_b;
      end
    end
  end

  // Synchronizer and edge detector for the two selected oscillators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_r <= '0;
      sync_b_r <= '0;
    end else if (take_s) begin
      sync_a_r <= '0;
      sync_b_r <= '0;
    end else begin
      sync_a_r <= {sync_a_r[1:0], pick(ro_out, sel_a_r)};
      sync_b_r <= {sync_b_r[1:0], pick(ro_out, sel_b_r)};
    end
  end

  // Registered control outputs, derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_en_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      ro_en_r <= ((state_nxt_s == S_SETTLE) || (state_nxt_s == S_MEASURE)) ? en_mask_s : '0;
      busy_r  <= (state_nxt_s != S_IDLE);
      done_r  <= (state_nxt_s == S_DONE);
    end
  end

  // Result registers: captured on DONE entry, held until the next start is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      response_r <= 1'b0;
      tie_r      <= 1'b0;
      err_r      <= 1'b0;
    end else if (finish_s) begin
      response_r <= (cnt_a_nxt_s > cnt_b_nxt_s);
      tie_r      <= (cnt_a_nxt_s == cnt_b_nxt_s);
      err_r      <= 1'b0;
    end else if (take_s) begin
      response_r <= 1'b0;
      tie_r      <= 1'b0;
      err_r      <= ~valid_s;
    end
  end

`ifdef RO_PAIR_CNT_OUT_EN
  logic [CNT_W-1:0] cnt_a_hold_r, cnt_b_hold_r;

  // Held copies of the final counts for characterisation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_hold_r <= '0;
      cnt_b_hold_r <= '0;
    end else if (finish_s) begin
      cnt_a_hold_r <= cnt_a_nxt_s;
      cnt_b_hold_r <= cnt_b_nxt_s;
    end else if (take_s) begin
      cnt_a_hold_r <= '0;
      cnt_b_hold_r <= '0;
    end
  end

  assign cnt_a = cnt_a_hold_r;
  assign cnt_b = cnt_b_hold_r;
`endif

  assign ro_en    = ro_en_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign response = response_r;
  assign tie      = tie_r;
  assign err      = err_r;

endmodule

// File: tb/tb_ro_pair_sched.sv
// Table-driven bench for ro_pair_sched: a default instance plus a 12-oscillator, 4-bit-counter instance.
module tb_ro_pair_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [3:0]  sel_a, sel_b, sel_a2, sel_b2;
  logic [15:0] ro_out = 16'h0000;

  logic [15:0] ro_en1;
  logic        busy1, done1, resp1, tie1, err1;
  logic [11:0] ro_en2;
  logic        busy2, done2, resp2, tie2, err2;
`ifdef RO_PAIR_CNT_OUT_EN
  logic [15:0] cnt_a1, cnt_b1;
  logic [3:0]  cnt_a2, cnt_b2;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ro_pair_sched u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sel_a(sel_a), .sel_b(sel_b),
    .ro_out(ro_out), .ro_en(ro_en1), .busy(busy1), .done(done1),
    .response(resp1), .tie(tie1), .err(err1)
`ifdef RO_PAIR_CNT_OUT_EN
    , .cnt_a(cnt_a1), .cnt_b(cnt_b1)
`endif
  );

  ro_pair_sched #(.NUM_RO(12), .SEL_W(4), .CNT_W(4), .SETTLE(2), .WINDOW(100)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sel_a(sel_a2), .sel_b(sel_b2),
    .ro_out(ro_out[11:0]), .ro_en(ro_en2), .busy(busy2), .done(done2),
    .response(resp2), .tie(tie2), .err(err2)
`ifdef RO_PAIR_CNT_OUT_EN
    , .cnt_a(cnt_a2), .cnt_b(cnt_b2)
`endif
  );

  // Oscillator model: bit i toggles every HALF[i] clk cycles; large values never toggle.
  localparam int BIG = 1 << 30;
  localparam int HALF [16] = '{BIG, 2, BIG, 3, 4, 4, 4, BIG, BIG, BIG, BIG, BIG, BIG, BIG, BIG, BIG};
  int osc_cyc = 1;
  always @(negedge clk) begin
    osc_cyc <= osc_cyc + 1;
    for (int i = 0; i < 16; i++) begin
      if ((osc_cyc % HALF[i]) == 0) ro_out[i] <= ~ro_out[i];
    end
  end

  typedef struct {
    bit          inst;
    logic [3:0]  a;
    logic [3:0]  b;
    bit          e_err;
    bit          e_resp;
    bit          e_tie;
    int          e_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic run(input int idx, input vec_t v, input bit poke);
    int          done_edge;
    int          ro_bad;
    int          busy_bad;
    logic [15:0] exp_mask;
    logic [15:0] cur_en;
    logic        cur_done, cur_busy;
    exp_mask = v.e_err ? 16'h0000 : ((16'h0001 << v.a) | (16'h0001 << v.b));
    @(negedge clk);
    if (v.inst) begin
      sel_a2 = v.a; sel_b2 = v.b; start2 = 1'b1;
    end else begin
      sel_a = v.a; sel_b = v.b; start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
    done_edge = -1; ro_bad = 0; busy_bad = 0;
    for (int e = 0; e < 1200; e++) begin
      cur_en   = v.inst ? {4'h0, ro_en2} : ro_en1;
      cur_done = v.inst ? done2 : done1;
      cur_busy = v.inst ? busy2 : busy1;
      if (cur_en != ((!v.e_err && e < v.e_lat - 3) ? exp_mask : 16'h0000)) ro_bad++;
      if (!cur_busy) busy_bad++;
      if (cur_done) begin
        done_edge = e;
        break;
      end
      start = (poke && (e == 200 || e == 1005)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check($sformatf("v%0d done_edge", idx), done_edge, v.e_lat);
    check($sformatf("v%0d ro_en_bad_cycles", idx), ro_bad, 0);
    check($sformatf("v%0d busy_low_cycles", idx), busy_bad, 0);
    check($sformatf("v%0d err", idx), v.inst ? err2 : err1, v.e_err);
    check($sformatf("v%0d response", idx), v.inst ? resp2 : resp1, v.e_resp);
    check($sformatf("v%0d tie", idx), v.inst ? tie2 : tie1, v.e_tie);
    @(posedge clk); #1;
    check($sformatf("v%0d done_after", idx), v.inst ? done2 : done1, 0);
    check($sformatf("v%0d busy_after", idx), v.inst ? busy2 : busy1, 0);
    check($sformatf("v%0d response_held", idx), v.inst ? resp2 : resp1, v.e_resp);
  endtask

  initial begin
    int ndone;
    vecs[0] = '{1'b0, 4'd3,  4'd5,  1'b0, 1'b1, 1'b0, 1007};
    vecs[1] = '{1'b0, 4'd5,  4'd3,  1'b0, 1'b0, 1'b0, 1007};
    vecs[2] = '{1'b0, 4'd5,  4'd6,  1'b0, 1'b0, 1'b1, 1007};
    vecs[3] = '{1'b0, 4'd7,  4'd7,  1'b1, 1'b0, 1'b0, 0};
    vecs[4] = '{1'b0, 4'd0,  4'd3,  1'b0, 1'b0, 1'b0, 1007};
    vecs[5] = '{1'b1, 4'd2,  4'd15, 1'b1, 1'b0, 1'b0, 0};
    vecs[6] = '{1'b1, 4'd1,  4'd4,  1'b0, 1'b1, 1'b0, 105};
    vecs[7] = '{1'b1, 4'd4,  4'd1,  1'b0, 1'b0, 1'b0, 105};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    sel_a = 4'd0; sel_b = 4'd0; sel_a2 = 4'd0; sel_b2 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ro_en", ro_en1, 0);
    check("reset busy", busy1, 0);
    check("reset done", done1, 0);
    check("reset response", resp1, 0);
    check("reset tie", tie1, 0);
    check("reset err", err1, 0);
    check("reset ro_en2", ro_en2, 0);
`ifdef RO_PAIR_CNT_OUT_EN
    check("reset cnt_a", cnt_a1, 0);
    check("reset cnt_b", cnt_b1, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run(i, vecs[i], 1'b0);
`ifdef RO_PAIR_CNT_OUT_EN
      if (i == 0) begin
        check_rng("v0 cnt_a", cnt_a1, 166, 168);
        check_rng("v0 cnt_b", cnt_b1, 124, 126);
      end
      if (i == 6) begin
        check("v6 cnt_a saturated", cnt_a2, 15);
        check_rng("v6 cnt_b", cnt_b2, 11, 14);
      end
`endif
    end

    // Reset in the middle of a measurement.
    @(negedge clk);
    sel_a = 4'd3; sel_b = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    check("midrun ro_en before reset", ro_en1, 16'h0028);
    rst_n = 1'b0;
    #1;
    check("midrun ro_en after reset", ro_en1, 0);
    check("midrun busy after reset", busy1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 1100; c++) begin
      @(posedge clk); #1;
      if (done1) ndone++;
    end
    check("midrun no done pulse", ndone, 0);
    run(10, vecs[0], 1'b0);

    // Start pulses while busy must not be queued.
    run(11, vecs[1], 1'b1);
    ndone = 0;
    for (int c = 0; c < 1100; c++) begin
      @(posedge clk); #1;
      if (done1) ndone++;
    end
    check("busy start ignored", ndone, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
